alu_key_loader: RTL and testbench

- Supplier side of the ALU logic-locking interface: drives the `locking_key` bus consumed by the obfuscated ALU datapath.
- Receives the key serially from the secure key store, MSB first, followed by one even-parity bit.
- Checks parity and only then commits the key to the output.
- Until a good key is committed, `locking_key` holds all-zero, which leaves the locked ALU in its wrong-function state.

---
 rtl/alu_key_loader.sv | 98 +++++++++
 tb/tb_alu_key_loader.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/alu_key_loader.sv
// alu_key_loader: serial MSB-first key receiver with even-parity check driving the ALU locking_key bus.
// Optional KEY_ZEROIZE_EN: a parity failure also clears locking_key and key_valid.
module alu_key_loader #(
    parameter int KEY_W = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic             key_bit,
    input  logic             key_bit_valid,
    output logic             busy,
    output logic [KEY_W-1:0] locking_key,
    output logic             key_valid,
    output logic             key_err
);
    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(KEY_W);
    state_t           state_q, state_d;
    logic [KEY_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    logic [KEY_W-1:0] key_q, key_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            key_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            key_q   <= key_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        key_d   = key_q;
        valid_d = valid_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (load_start) begin
                state_d = SHIFT;
                shift_d = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end
            SHIFT: if (load_start) begin
                // restart wins over a same-cycle key bit, which is dropped
                shift_d = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
            end else if (key_bit_valid) begin
                if (cnt_q < LAST) begin
                    shift_d = {shift_q[KEY_W-2:0], key_bit};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
                    par_d   = key_bit;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if ((^shift_q ^ par_q) == 1'b0) begin
                    key_d   = shift_q;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                end else begin
                    err_d   = 1'b1;
`ifdef KEY_ZEROIZE_EN
                    key_d   = '0;
                    valid_d = 1'b0;
`else
                    key_d   = key_q;
                    valid_d = valid_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign busy        = (state_q != IDLE);
    assign locking_key = key_q;
    assign key_valid   = valid_q;
    assign key_err     = err_q;
endmodule

// File: tb/tb_alu_key_loader.sv
// tb_alu_key_loader: directed frames checked each cycle against a frame-level model plus literal checkpoints.
module tb_alu_key_loader;
    localparam int KEY_W = 8;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic load_start = 1'b0;
    logic key_bit = 1'b0;
    logic key_bit_valid = 1'b0;
    logic busy, key_valid, key_err;
    logic [KEY_W-1:0] locking_key;
    int n_tests = 0;
    int n_fail = 0;
    bit en = 1'b0;

    alu_key_loader #(.KEY_W(KEY_W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(load_start), .key_bit(key_bit),
        .key_bit_valid(key_bit_valid), .busy(busy), .locking_key(locking_key),
        .key_valid(key_valid), .key_err(key_err)
    );

    always #5 clk = ~clk;

    // frame-level model: collected bits as an integer, parity judged by popcount
    logic        m_busy, m_check, m_par, m_valid, m_err;
    int          m_n;
    logic [31:0] m_val;
    logic [7:0]  m_key;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_check <= 0; m_par <= 0; m_valid <= 0; m_err <= 0;
            m_n <= 0; m_val <= 0; m_key <= 0;
        end else if (m_check) begin
            m_check <= 0;
            m_busy  <= 0;
            if ((($countones(m_val) + int'(m_par)) % 2) == 0) begin
                m_key <= m_val[7:0]; m_valid <= 1; m_err <= 0;
            end else begin
                m_err <= 1;
`ifdef KEY_ZEROIZE_EN
                m_key <= 0; m_valid <= 0;
`endif
            end
        end else if (load_start) begin
            m_busy <= 1; m_n <= 0; m_val <= 0; m_err <= 0;
        end else if (m_busy && key_bit_valid) begin
            if (m_n < KEY_W) begin
                m_val <= m_val * 2 + 32'(key_bit);
                m_n   <= m_n + 1;
            end else begin
                m_par   <= key_bit;
                m_check <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (en) begin
        chk("busy", 32'(busy), 32'(m_busy));
        chk("locking_key", 32'(locking_key), 32'(m_key));
        chk("key_valid", 32'(key_valid), 32'(m_valid));
        chk("key_err", 32'(key_err), 32'(m_err));
    end

    task automatic drive(input logic ls, input logic v, input logic b);
        @(posedge clk);
        #2;
        load_start = ls; key_bit_valid = v; key_bit = b;
    endtask

    task automatic frame(input logic [7:0] k, input logic par, input int gap, input logic ls_in_check);
        drive(1, 0, 0);
        for (int i = KEY_W - 1; i >= 0; i--) begin
            drive(0, 1, k[i]);
            repeat (gap) drive(0, 0, 0);
        end
        drive(0, 1, par);
        drive(ls_in_check, 0, 0);
        drive(0, 0, 0);
    endtask

    task automatic lit(input string name, input logic [7:0] k, input logic v, input logic e, input logic b);
        chk({name, "_key"}, 32'(locking_key), 32'(k));
        chk({name, "_valid"}, 32'(key_valid), 32'(v));
        chk({name, "_err"}, 32'(key_err), 32'(e));
        chk({name, "_busy"}, 32'(busy), 32'(b));
    endtask

    initial begin
        #1;
        en = 1'b1;
        lit("reset", 8'h00, 0, 0, 0);
        drive(0, 0, 0);
        rst_n = 1'b1;
        drive(0, 1, 1);
        drive(0, 1, 0);
        drive(0, 0, 0);
        lit("idle_ignore", 8'h00, 0, 0, 0);
        frame(8'hA5, 0, 0, 0);
        lit("good", 8'hA5, 1, 0, 0);
        frame(8'h3C, 1, 0, 0);
`ifdef KEY_ZEROIZE_EN
        lit("badpar", 8'h00, 0, 1, 0);
`else
        lit("badpar", 8'hA5, 1, 1, 0);
`endif
        drive(1, 0, 0);
        drive(0, 0, 0);
        chk("err_clear_on_start", 32'(key_err), 32'(0));
        chk("busy_after_start", 32'(busy), 32'(1));
        drive(0, 0, 0);
        frame(8'hFF, 0, 3, 0);
        lit("gapped", 8'hFF, 1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1);
        drive(1, 1, 1);
        for (int i = KEY_W - 1; i >= 0; i--) begin
            logic [7:0] r;
            r = 8'h81;
            drive(0, 1, r[i]);
        end
        drive(0, 1, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        lit("restart", 8'h81, 1, 0, 0);
        frame(8'hC3, 0, 0, 1);
        lit("ls_in_check", 8'hC3, 1, 0, 0);
        drive(0, 0, 0);
        chk("ls_in_check_idle", 32'(busy), 32'(0));
        frame(8'hA5, 0, 0, 0);
        lit("reload", 8'hA5, 1, 0, 0);
        drive(1, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, 1, 1);
        #3;
        rst_n = 1'b0;
        #1;
        lit("async_rst", 8'h00, 0, 0, 0);
        drive(0, 0, 0);
        rst_n = 1'b1;
        frame(8'h5A, 0, 0, 0);
        lit("after_rst", 8'h5A, 1, 0, 0);
        repeat (2) drive(0, 0, 0);
        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
